// File: rtl/decodificador_7seg_scan_pkg.sv
// Shared constants for the 7-segment scan monitor: segment patterns
// (bit 6 = a ... bit 0 = g, active-high) and decoded code values.
package decodificador_7seg_scan_pkg;

  localparam int ANCHO_COD = 5;

  localparam logic [6:0] SEG_0      = 7'b1111110;
  localparam logic [6:0] SEG_1      = 7'b0110000;
  localparam logic [6:0] SEG_2      = 7'b1101101;
  localparam logic [6:0] SEG_3      = 7'b1111001;
  localparam logic [6:0] SEG_4      = 7'b0110011;
  localparam logic [6:0] SEG_5      = 7'b1011011;
  localparam logic [6:0] SEG_6      = 7'b1011111;
  localparam logic [6:0] SEG_7      = 7'b1110000;
  localparam logic [6:0] SEG_8      = 7'b1111111;
  localparam logic [6:0] SEG_9      = 7'b1111011;
  localparam logic [6:0] SEG_A      = 7'b1110111;
  localparam logic [6:0] SEG_B      = 7'b0011111;
  localparam logic [6:0] SEG_C      = 7'b1001110;
  localparam logic [6:0] SEG_D      = 7'b0111101;
  localparam logic [6:0] SEG_E      = 7'b1001111;
  localparam logic [6:0] SEG_F      = 7'b1000111;
  localparam logic [6:0] SEG_BLANCO = 7'b0000000;
  localparam logic [6:0] SEG_GUION  = 7'b0000001;

  localparam logic [ANCHO_COD-1:0] COD_BLANCO   = 5'd16;
  localparam logic [ANCHO_COD-1:0] COD_GUION    = 5'd17;
  localparam logic [ANCHO_COD-1:0] COD_INVALIDO = 5'd31;

endpackage

// File: rtl/decodificador_7seg_scan_segmentos_a_hex.sv
// Combinational inverse of the hex-to-7-segment table: pattern -> {valid, code}.
module segmentos_a_hex
  import decodificador_7seg_scan_pkg::*;
(
  input  logic [6:0]           segmentos_i,
  output logic                 valido_o,
  output logic [ANCHO_COD-1:0] codigo_o
);

  always_comb begin
    valido_o = 1'b1;
    codigo_o = COD_INVALIDO;
    case (segmentos_i)
      SEG_0:      codigo_o = 5'd0;
      SEG_1:      codigo_o = 5'd1;
      SEG_2:      codigo_o = 5'd2;
      SEG_3:      codigo_o = 5'd3;
      SEG_4:      codigo_o = 5'd4;
      SEG_5:      codigo_o = 5'd5;
      SEG_6:      codigo_o = 5'd6;
      SEG_7:      codigo_o = 5'd7;
      SEG_8:      codigo_o = 5'd8;
      SEG_9:      codigo_o = 5'd9;
      SEG_A:      codigo_o = 5'd10;
      SEG_B:      codigo_o = 5'd11;
      SEG_C:      codigo_o = 5'd12;
      SEG_D:      codigo_o = 5'd13;
      SEG_E:      codigo_o = 5'd14;
      SEG_F:      codigo_o = 5'd15;
      SEG_BLANCO: codigo_o = COD_BLANCO;
      SEG_GUION:  codigo_o = COD_GUION;
      default: begin
        valido_o = 1'b0;
        codigo_o = COD_INVALIDO;
      end
    endcase
  end

endmodule

// File: rtl/decodificador_7seg_scan.sv
// Multiplexed 7-segment bus monitor: debounces each (anodos, segmentos) pair,
// decodes it and stores the code of the selected digit.
module decodificador_7seg_scan
  import decodificador_7seg_scan_pkg::*;
#(
  parameter int N_DIGITOS = 4,
  parameter int ESTABLE   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [6:0]                     segmentos,
  input  logic [N_DIGITOS-1:0]           anodos,
  output logic [ANCHO_COD*N_DIGITOS-1:0] codigos,
  output logic [N_DIGITOS-1:0]           validos,
  output logic                           nuevo,
  output logic [((N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1)-1:0] indice,
  output logic                           error_patron,
  output logic                           error_anodo
);

  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = (ESTABLE > 1) ? $clog2(ESTABLE + 1) : 1;
  localparam int MW = N_DIGITOS + 7;
  localparam logic [CW-1:0] CNT_MAX     = CW'(ESTABLE);
  localparam logic [CW-1:0] CNT_DISPARO = CW'(ESTABLE - 1);

  logic [MW-1:0]                    muestra_q, muestra_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [ANCHO_COD*N_DIGITOS-1:0]   codigos_q, codigos_d;
  logic [N_DIGITOS-1:0]             validos_q, validos_d;
  logic [IW-1:0]                    indice_q, indice_d;
  logic                             nuevo_q, nuevo_d;
  logic                             errp_q, errp_d;
  logic                             erra_q, erra_d;

  logic [MW-1:0]        pines;
  logic                 igual;
  logic                 captura;
  logic                 es_onehot;
  logic                 dec_valido;
  logic [ANCHO_COD-1:0] dec_codigo;

  segmentos_a_hex u_decod (
    .segmentos_i (segmentos),
    .valido_o    (dec_valido),
    .codigo_o    (dec_codigo)
  );

  assign pines     = {anodos, segmentos};
  assign igual     = (pines == muestra_q);
  assign captura   = igual && (cnt_q == CNT_DISPARO);
  assign es_onehot = ((anodos & (anodos - 1'b1)) == '0);

  // Capture compares against the current pins, so a change on the firing edge cancels it.
  always_comb begin
    muestra_d = pines;
    cnt_d     = cnt_q;
    codigos_d = codigos_q;
    validos_d = validos_q;
    indice_d  = indice_q;
    nuevo_d   = 1'b0;
    errp_d    = 1'b0;
    erra_d    = 1'b0;

    if (!igual) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (captura && (anodos != '0)) begin
      if (!es_onehot) begin
        erra_d = 1'b1;
      end else begin
        for (int i = 0; i < N_DIGITOS; i++) begin
          if (anodos[i]) begin
            codigos_d[ANCHO_COD*i +: ANCHO_COD] = dec_valido ? dec_codigo : COD_INVALIDO;
            validos_d[i] = dec_valido;
            indice_d     = IW'(i);
          end
        end
        nuevo_d = 1'b1;
        errp_d  = !dec_valido;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      muestra_q <= '0;
      cnt_q     <= '0;
      codigos_q <= {N_DIGITOS{COD_BLANCO}};
      validos_q <= '0;
      indice_q  <= '0;
      nuevo_q   <= 1'b0;
      errp_q    <= 1'b0;
      erra_q    <= 1'b0;
    end else begin
      muestra_q <= muestra_d;
      cnt_q     <= cnt_d;
      codigos_q <= codigos_d;
      validos_q <= validos_d;
      indice_q  <= indice_d;
      nuevo_q   <= nuevo_d;
      errp_q    <= errp_d;
      erra_q    <= erra_d;
    end
  end

  assign codigos      = codigos_q;
  assign validos      = validos_q;
  assign indice       = indice_q;
  assign nuevo        = nuevo_q;
  assign error_patron = errp_q;
  assign error_anodo  = erra_q;

endmodule
